// File: rtl/ecg_argmax_classifier.sv
// Argmax stage after the layer-2 nodes: captures all activations, scans them one per
// cycle, and reports winning class, its value, margin to runner-up and a tie flag.
module ecg_argmax_classifier #(
    parameter int NUM_IN = 8,
    parameter int DW     = 8,
    parameter int IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_IN*DW-1:0] act_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     class_idx,
    output logic [DW-1:0]        max_val,
    output logic [DW-1:0]        margin,
    output logic                 tie_flag
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IN - 1);

    state_t state;
    state_t state_nxt;

    logic [NUM_IN*DW-1:0] cap;
    logic [IDX_W-1:0]     cnt;
    logic [DW-1:0]        elem;
    logic [DW-1:0]        max_r;
    logic [DW-1:0]        sec_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 tie_r;
    logic [DW-1:0]        max_nxt;
    logic [DW-1:0]        sec_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 tie_nxt;
    logic                 accept;
    logic                 last;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == LAST);
    assign elem   = cap[int'(cnt)*DW +: DW];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)    state_nxt = SCAN;
            SCAN: if (last)      state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
    end

    // Running max/second update; an equal value keeps the earlier index.
    always_comb begin
        max_nxt = max_r;
        sec_nxt = sec_r;
        idx_nxt = idx_r;
        tie_nxt = tie_r;
        if (cnt == '0) begin
            max_nxt = elem;
            sec_nxt = '0;
            idx_nxt = '0;
            tie_nxt = 1'b0;
        end else if (elem > max_r) begin
            sec_nxt = max_r;
            max_nxt = elem;
            idx_nxt = cnt;
            tie_nxt = 1'b0;
        end else if (elem == max_r) begin
            sec_nxt = max_r;
            tie_nxt = 1'b1;
        end else if (elem > sec_r) begin
            sec_nxt = elem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap       <= '0;
            cnt       <= '0;
            max_r     <= '0;
            sec_r     <= '0;
            idx_r     <= '0;
            tie_r     <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            margin    <= '0;
            tie_flag  <= 1'b0;
        end else begin
            if (accept) begin
                cap <= act_bus;
                cnt <= '0;
            end
            if (state == SCAN) begin
                max_r <= max_nxt;
                sec_r <= sec_nxt;
                idx_r <= idx_nxt;
                tie_r <= tie_nxt;
                if (last) begin
                    class_idx <= idx_nxt;
                    max_val   <= max_nxt;
                    margin    <= max_nxt - sec_nxt;
                    tie_flag  <= tie_nxt;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ecg_argmax_classifier.sv
// Randomized self-checking bench for ecg_argmax_classifier against a
// sort-based reference model.
module tb_ecg_argmax_classifier;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int IW = 4;

    logic            clk = 0;
    logic            reset = 1;
    logic            in_valid = 0;
    logic            in_ready;
    logic [N*DW-1:0] act_bus = '0;
    logic            out_valid;
    logic            out_ready = 0;
    logic [IW-1:0]   class_idx;
    logic [DW-1:0]   max_val;
    logic [DW-1:0]   margin;
    logic            tie_flag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ecg_argmax_classifier #(.NUM_IN(N), .DW(DW), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .act_bus(act_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .max_val(max_val),
        .margin(margin), .tie_flag(tie_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: max is the first index of the largest value, margin is the
    // gap between the top two entries of the sorted list, tie if max repeats.
    function automatic void ref_model(input logic [N*DW-1:0] bus,
                                      output logic [IW-1:0] idx,
                                      output logic [DW-1:0] mx,
                                      output logic [DW-1:0] mg,
                                      output logic tie);
        logic [DW-1:0] q[$];
        int hits;
        for (int k = 0; k < N; k++) q.push_back(bus[k*DW +: DW]);
        q.rsort();
        mx = q[0];
        mg = q[0] - q[1];
        hits = 0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (bus[k*DW +: DW] == mx) begin
                idx = IW'(k);
                hits++;
            end
        tie = (hits > 1);
    endfunction

    function automatic logic [N*DW-1:0] pack(input int v[N]);
        logic [N*DW-1:0] b;
        for (int k = 0; k < N; k++) b[k*DW +: DW] = DW'(v[k]);
        return b;
    endfunction

    function automatic logic [N*DW-1:0] rand_set(input int mode);
        logic [N*DW-1:0] b;
        for (int k = 0; k < N; k++)
            case (mode)
                0: b[k*DW +: DW] = DW'($urandom_range(0, 127));
                1: b[k*DW +: DW] = DW'($urandom_range(0, 255));
                default: b[k*DW +: DW] = DW'($urandom_range(0, 3));
            endcase
        return b;
    endfunction

    // Presents a set and returns just after its accept edge.
    task automatic send(input logic [N*DW-1:0] bus);
        int w = 0;
        @(negedge clk);
        in_valid = 1;
        act_bus  = bus;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        act_bus  = {$urandom, $urandom};
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 60);
    endtask

    task automatic pop();
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got %b required 0", in_ready);
        end
        reset = 0;
        #1;
        checks++;
        if ({in_ready, out_valid, class_idx, max_val, margin, tie_flag}
            !== {1'b1, 1'b0, {IW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_state rdy=%b ov=%b idx=%0d max=%0d mg=%0d tie=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, class_idx, max_val, margin, tie_flag);
        end
    endtask

    task automatic test_basic();
        int lat;
        send(pack('{10, 20, 127, 5, 0, 0, 0, 0}));
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy in_ready=%b required 0", in_ready);
        end
        wait_result(lat);
        checks++;
        if (lat !== N) begin
            errors++;
            $display("FAIL basic_latency got %0d required %0d", lat, N);
        end
        checks++;
        if ({class_idx, max_val, margin, tie_flag} !== {4'd2, 8'd127, 8'd107, 1'b0}) begin
            errors++;
            $display("FAIL basic_result idx=%0d max=%0d mg=%0d tie=%b required 2 127 107 0",
                     class_idx, max_val, margin, tie_flag);
        end
        pop();
        checks++;
        if ({out_valid, in_ready, class_idx, max_val} !== {1'b0, 1'b1, 4'd2, 8'd127}) begin
            errors++;
            $display("FAIL basic_pop ov=%b rdy=%b idx=%0d max=%0d required 0 1 2 127",
                     out_valid, in_ready, class_idx, max_val);
        end
    endtask

    task automatic test_patterns();
        logic [N*DW-1:0] sets[$];
        logic [IW-1:0] ei;
        logic [DW-1:0] em, eg;
        logic et;
        int lat;
        sets.push_back(pack('{0, 50, 50, 10, 0, 0, 0, 50}));
        sets.push_back('0);
        sets.push_back(pack('{1, 1, 1, 1, 1, 1, 1, 9}));
        sets.push_back(pack('{200, 255, 128, 255, 3, 0, 254, 1}));
        for (int i = 0; i < 40; i++) sets.push_back(rand_set(i % 3));
        foreach (sets[i]) begin
            ref_model(sets[i], ei, em, eg, et);
            send(sets[i]);
            wait_result(lat);
            checks++;
            if (lat !== N) begin
                errors++;
                $display("FAIL pat%0d_latency got %0d required %0d", i, lat, N);
            end
            checks++;
            if ({class_idx, max_val, margin, tie_flag} !== {ei, em, eg, et}) begin
                errors++;
                $display("FAIL pat%0d_result idx=%0d max=%0d mg=%0d tie=%b required %0d %0d %0d %b",
                         i, class_idx, max_val, margin, tie_flag, ei, em, eg, et);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                checks++;
                if ({out_valid, class_idx, max_val} !== {1'b1, ei, em}) begin
                    errors++;
                    $display("FAIL pat%0d_hold ov=%b idx=%0d max=%0d required 1 %0d %0d",
                             i, out_valid, class_idx, max_val, ei, em);
                end
            end
            pop();
        end
    endtask

    task automatic test_backpressure();
        logic [N*DW-1:0] a, b;
        logic [IW-1:0] ei;
        logic [DW-1:0] em, eg;
        logic et;
        int lat;
        int bad = 0;
        a = rand_set(0);
        b = rand_set(1);
        ref_model(a, ei, em, eg, et);
        send(a);
        wait_result(lat);
        in_valid = 1;
        act_bus  = b;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if ({out_valid, in_ready, class_idx, max_val, margin, tie_flag}
                !== {1'b1, 1'b0, ei, em, eg, et}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold bad_cycles=%0d required 0", bad);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release ov=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        ref_model(b, ei, em, eg, et);
        @(posedge clk);
        #1;
        in_valid = 0;
        act_bus  = '0;
        wait_result(lat);
        checks++;
        if (lat !== N || {class_idx, max_val, margin, tie_flag} !== {ei, em, eg, et}) begin
            errors++;
            $display("FAIL bp_pending lat=%0d idx=%0d max=%0d mg=%0d tie=%b required %0d %0d %0d %0d %b",
                     lat, class_idx, max_val, margin, tie_flag, N, ei, em, eg, et);
        end
        pop();
    endtask

    task automatic test_reset_mid_scan();
        logic [IW-1:0] ei;
        logic [DW-1:0] em, eg;
        logic et;
        int lat;
        int seen = 0;
        send(pack('{3, 90, 4, 90, 7, 1, 2, 0}));
        repeat (4) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        checks++;
        if ({in_ready, out_valid, class_idx, max_val, margin, tie_flag}
            !== {1'b1, 1'b0, {IW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL abort_state rdy=%b ov=%b idx=%0d max=%0d mg=%0d tie=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, class_idx, max_val, margin, tie_flag);
        end
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_valid pulses=%0d required 0", seen);
        end
        ref_model(pack('{9, 8, 7, 6, 5, 4, 3, 2}), ei, em, eg, et);
        send(pack('{9, 8, 7, 6, 5, 4, 3, 2}));
        wait_result(lat);
        checks++;
        if (lat !== N || {class_idx, max_val, margin, tie_flag} !== {ei, em, eg, et}) begin
            errors++;
            $display("FAIL abort_recover lat=%0d idx=%0d max=%0d mg=%0d tie=%b required %0d %0d %0d %0d %b",
                     lat, class_idx, max_val, margin, tie_flag, N, ei, em, eg, et);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] s[3];
        logic [IW-1:0] ei;
        logic [DW-1:0] em, eg;
        logic et;
        int lat;
        int prev = 0;
        int extra = 0;
        for (int i = 0; i < 3; i++) s[i] = rand_set(i);
        out_ready = 1;
        @(negedge clk);
        in_valid = 1;
        act_bus  = s[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            act_bus = (i < 2) ? s[i+1] : {$urandom, $urandom};
            ref_model(s[i], ei, em, eg, et);
            wait_result(lat);
            checks++;
            if (lat !== N || {class_idx, max_val, margin, tie_flag} !== {ei, em, eg, et}) begin
                errors++;
                $display("FAIL b2b%0d lat=%0d idx=%0d max=%0d mg=%0d tie=%b required %0d %0d %0d %0d %b",
                         i, lat, class_idx, max_val, margin, tie_flag, N, ei, em, eg, et);
            end
            if (i > 0) begin
                checks++;
                if (cyc - prev != N + 2) begin
                    errors++;
                    $display("FAIL b2b%0d_spacing got %0d required %0d", i, cyc - prev, N + 2);
                end
            end
            prev = cyc;
            if (i == 2) in_valid = 0;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL b2b%0d_pop ov=%b rdy=%b required 0 1", i, out_valid, in_ready);
            end
        end
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_duplicate extra=%0d required 0", extra);
        end
        out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
